// File: rtl/fifo_push_arbiter.sv
// Round-robin arbiter sharing one FiFo push port among NUM_REQ valid/ready producers.
// A grant is held for up to MAX_BURST accepted transfers and is then handed on without a bubble.
//
// state | meaning
// IDLE  | no owner; arbitrate over req_valid from rr_ptr
// GRANT | owner registered; owner's data drives fifo_din/fifo_push
module fifo_push_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 2,
    parameter int MAX_BURST  = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [DATA_WIDTH-1:0]         fifo_din,
    output logic                          fifo_push,
    input  logic                          fifo_full,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id,
    output logic                          busy
);

    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t                state;
    logic [ID_W-1:0]       owner;
    logic [ID_W-1:0]       rr_ptr;
    logic [CNT_W-1:0]      burst_cnt;

    logic [ID_W-1:0]       owner_next;
    logic [ID_W-1:0]       scan_ptr;
    logic [ID_W-1:0]       pick_id;
    logic                  pick_valid;
    logic                  active;
    logic                  owner_valid;
    logic                  accept;
    logic                  release_now;
    logic [DATA_WIDTH-1:0] lane_data [NUM_REQ];

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            lane_data[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    always_comb begin
        if (owner == ID_W'(NUM_REQ - 1)) begin
            owner_next = '0;
        end else begin
            owner_next = owner + ID_W'(1);
        end
    end

    // On release the scan already starts past the old owner, so the hand-over needs no idle cycle.
    assign scan_ptr = (state == GRANT) ? owner_next : rr_ptr;

    always_comb begin
        logic [ID_W-1:0] idx;
        pick_valid = 1'b0;
        pick_id    = '0;
        idx        = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx = ID_W'((int'(scan_ptr) + i) % NUM_REQ);
            if (req_valid[idx]) begin
                pick_valid = 1'b1;
                pick_id    = idx;
            end
        end
    end

    // Outputs are forced quiet while rst is high so an in-flight word is never pushed.
    assign active      = (state == GRANT) && !rst;
    assign owner_valid = req_valid[owner];
    assign accept      = active && owner_valid && !fifo_full;
    assign release_now = active && (!owner_valid || (accept && (burst_cnt == LAST_BEAT)));

    always_comb begin
        req_ready = '0;
        if (active) begin
            req_ready[owner] = !fifo_full;
        end
    end

    assign fifo_push = accept;
    assign fifo_din  = active ? lane_data[owner] : '0;
    assign grant_id  = active ? owner : '0;
    assign busy      = active;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            owner     <= '0;
            rr_ptr    <= '0;
            burst_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        state     <= GRANT;
                        owner     <= pick_id;
                        burst_cnt <= '0;
                    end
                end
                GRANT: begin
                    if (release_now) begin
                        rr_ptr    <= owner_next;
                        burst_cnt <= '0;
                        if (pick_valid) begin
                            owner <= pick_id;
                        end else begin
                            state <= IDLE;
                        end
                    end else if (accept) begin
                        burst_cnt <= burst_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
